// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the 8N1 UART receiver and transmitter.
//   - rx_state_t : FSM state encoding (IDLE/START/DATA/STOP), common to rx and tx
//   - CLKS_PER_BIT_DEFAULT : 50 MHz / 9600 baud
//   - CNT_W : width of the per-bit clock counter (covers CLKS_PER_BIT up to 8191)
//   - maj3 : 2-of-3 majority helper used by the optional sample vote
package uart_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 5208;
    localparam int CNT_W                = 13;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } rx_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: brings the asynchronous serial line into the clk domain.
//   clk     in  : board clock
//   rst_n   in  : asynchronous active-low reset
//   in_rx   in  : raw serial line (idles high)
//   rx_s    out : line after a 2-flop synchronizer (both flops reset to 1)
//   rx_vote out : value to use at a sample point
// Build option UART_RX_MAJORITY_EN: when defined, rx_vote is the 2-of-3
// majority of rx_s over the current and two previous clocks; otherwise
// rx_vote is rx_s itself.
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic in_rx,
    output logic rx_s,
    output logic rx_vote
);

    logic rx_meta;

    // Reset to 1 so the receiver never sees a false start bit out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= in_rx;
            rx_s    <= rx_meta;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // rx_hist[0] is rx_s one clock ago, rx_hist[1] two clocks ago. When the
    // FSM sits at its target count, the vote covers target-2, target-1, target.
    logic [1:0] rx_hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_hist <= 2'b11;
        end else begin
            rx_hist <= {rx_hist[0], rx_s};
        end
    end

    assign rx_vote = maj3(rx_s, rx_hist[0], rx_hist[1]);
`else
    assign rx_vote = rx_s;
`endif

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver (start bit, 8 data bits LSB first, 1 stop bit).
// Parameters:
//   CLKS_PER_BIT  : clocks per bit, legal 8..8191 (default 5208 = 50 MHz / 9600)
// Ports:
//   clk           in  : board clock, single domain
//   rst_n         in  : asynchronous active-low reset
//   in_rx         in  : serial line, asynchronous, idles high
//   data_received out : last good byte, held until the next good frame
//   rx_active     out : high while a frame is in progress (state != IDLE)
//   done          out : one-cycle strobe for a good frame
//   frame_error   out : one-cycle strobe for a stop bit sampled low
//   state_dbg     out : current FSM state, for observation only
// Build option UART_RX_MAJORITY_EN (see uart_rx_sync): 2-of-3 vote at every
// sample point; sample positions and strobe timing are unchanged.
//
// Output handshake: there is no back-pressure. done and frame_error are
// mutually exclusive single-cycle strobes; when done is high, data_received
// already holds the new byte and stays stable until the next done. A consumer
// must capture on the strobe cycle.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_rx,
    output logic [7:0] data_received,
    output logic       rx_active,
    output logic       done,
    output logic       frame_error,
    output logic [1:0] state_dbg
);

    // HALF puts the start-bit check mid-bit; every later sample is a whole
    // bit after it, so data and stop bits are also sampled mid-bit.
    localparam logic [CNT_W-1:0] HALF     = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic rx_s;
    logic rx_vote;

    uart_rx_sync u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_rx   (in_rx),
        .rx_s    (rx_s),
        .rx_vote (rx_vote)
    );

    rx_state_t        state,         state_nxt;
    logic [CNT_W-1:0] counter,       counter_nxt;
    logic [2:0]       bit_index,     bit_index_nxt;
    logic [7:0]       shift,         shift_nxt;
    logic [7:0]       data_nxt;
    logic             done_nxt;
    logic             frame_error_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            counter       <= '0;
            bit_index     <= '0;
            shift         <= '0;
            data_received <= '0;
            done          <= 1'b0;
            frame_error   <= 1'b0;
        end else begin
            state         <= state_nxt;
            counter       <= counter_nxt;
            bit_index     <= bit_index_nxt;
            shift         <= shift_nxt;
            data_received <= data_nxt;
            done          <= done_nxt;
            frame_error   <= frame_error_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        counter_nxt     = counter;
        bit_index_nxt   = bit_index;
        shift_nxt       = shift;
        data_nxt        = data_received;
        done_nxt        = 1'b0;
        frame_error_nxt = 1'b0;

        case (state)
            IDLE: begin
                counter_nxt   = '0;
                bit_index_nxt = '0;
                // A low line here may also be the tail of a bad stop bit;
                // the START check sorts that out as a glitch.
                if (!rx_s) begin
                    state_nxt = START;
                end
            end

            START: begin
                if (counter == HALF) begin
                    counter_nxt = '0;
                    state_nxt   = rx_vote ? IDLE : DATA;
                end else begin
                    counter_nxt = counter + CNT_ONE;
                end
            end

            DATA: begin
                if (counter == BIT_LAST) begin
                    counter_nxt          = '0;
                    shift_nxt[bit_index] = rx_vote;
                    if (bit_index == 3'd7) begin
                        bit_index_nxt = '0;
                        state_nxt     = STOP;
                    end else begin
                        bit_index_nxt = bit_index + 3'd1;
                    end
                end else begin
                    counter_nxt = counter + CNT_ONE;
                end
            end

            STOP: begin
                // Sampling mid stop bit leaves half a bit to get back to IDLE
                // before a back-to-back frame's falling edge.
                if (counter == BIT_LAST) begin
                    counter_nxt = '0;
                    state_nxt   = IDLE;
                    if (rx_vote) begin
                        data_nxt = shift;
                        done_nxt = 1'b1;
                    end else begin
                        frame_error_nxt = 1'b1;
                    end
                end else begin
                    counter_nxt = counter + CNT_ONE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign rx_active = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

    localparam int CPB   = 16;
    localparam int FRAME = 10 * CPB;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_rx = 1'b1;
    logic [7:0] data_received;
    logic       rx_active;
    logic       done;
    logic       frame_error;
    logic [1:0] state_dbg;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_rx         (in_rx),
        .data_received (data_received),
        .rx_active     (rx_active),
        .done          (done),
        .frame_error   (frame_error),
        .state_dbg     (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    // exp_q entry: {is_frame_error, byte}
    logic [8:0] exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc   = 0;
    int         done_times[$];
    logic [7:0] model_last = 8'h00;
    logic       prev_done  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // The receiver looks at one point per bit, in the middle of it. A single
    // clock high pulse at the middle of a bit flips that bit unless the
    // majority vote is built in.
    function automatic logic [8:0] expect_frame(input logic [7:0] b, input logic stop_v,
                                                input int glitch_bit);
        logic [7:0] r;
        r = b;
`ifndef UART_RX_MAJORITY_EN
        if (glitch_bit >= 0) r[glitch_bit] = 1'b1;
`endif
        if (!stop_v) return {1'b1, 8'h00};
        return {1'b0, r};
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [8:0] e;
        cyc = cyc + 1;
        if (!rst_n) begin
            model_last = 8'h00;
            prev_done  = 1'b0;
        end else begin
            if (done || frame_error) begin
                check("strobe_exclusive", {31'd0, done & frame_error}, 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", {30'd0, done, frame_error}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_kind", {31'd0, frame_error}, {31'd0, e[8]});
                    if (!e[8]) begin
                        check("data_received", {24'd0, data_received}, {24'd0, e[7:0]});
                        model_last = e[7:0];
                        done_times.push_back(cyc);
                    end else begin
                        check("data_hold_on_error", {24'd0, data_received}, {24'd0, model_last});
                    end
                    check("rx_active_at_strobe", {31'd0, rx_active}, 32'd0);
                end
                if (done) check("done_width", {31'd0, prev_done}, 32'd0);
            end
            prev_done = done;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        in_rx = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives n_clk clocks of an 8N1 frame; glitch_at is a clock offset where
    // the line is forced high for one clock (-1 for none).
    task automatic send_frame(input logic [7:0] b, input logic stop_v,
                              input int glitch_at, input int n_clk);
        for (int c = 0; c < n_clk; c++) begin
            int   bi;
            logic v;
            bi = c / CPB;
            if (bi == 0)      v = 1'b0;
            else if (bi <= 8) v = b[bi-1];
            else              v = stop_v;
            if (c == glitch_at) v = 1'b1;
            in_rx = v;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame(input logic [7:0] b, input logic stop_v, input int glitch_bit);
        int g;
        g = (glitch_bit >= 0) ? (glitch_bit + 1) * CPB + CPB / 2 : -1;
        exp_q.push_back(expect_frame(b, stop_v, glitch_bit));
        send_frame(b, stop_v, g, FRAME);
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 400) begin
            @(posedge clk);
            #1;
            k++;
        end
        check(name, exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int seen;
        int diff;
        int n;
        logic [7:0] b;
        logic       sv;

        rst_n = 1'b0;
        in_rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_data", {24'd0, data_received}, 32'd0);
        check("reset_rx_active", {31'd0, rx_active}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_frame_error", {31'd0, frame_error}, 32'd0);
        rst_n = 1'b1;
        idle(5);

        // single byte
        frame(8'hA5, 1'b1, -1);
        idle(10);
        drain("drain_single");

        // back-to-back
        frame(8'h00, 1'b1, -1);
        frame(8'hFF, 1'b1, -1);
        idle(10);
        drain("drain_b2b");
        n = done_times.size();
        diff = (n >= 2) ? done_times[n-1] - done_times[n-2] : 0;
        check("b2b_spacing_ok", {31'd0, (diff >= 158 && diff <= 162)}, 32'd1);

        // glitch rejection
        in_rx = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        in_rx = 1'b1;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (rx_active) seen = 1;
        end
        check("glitch_rx_active_pulse", seen, 32'd1);
        check("glitch_back_idle", {31'd0, rx_active}, 32'd0);
        idle(10);

        // framing error then recovery
        frame(8'h3C, 1'b0, -1);
        idle(20);
        drain("drain_ferr");
        frame(8'h81, 1'b1, -1);
        idle(10);
        drain("drain_after_ferr");

        // reset during bit 4
        send_frame(8'h55, 1'b1, -1, 5 * CPB + CPB / 2);
        rst_n = 1'b0;
        #1;
        check("midreset_data", {24'd0, data_received}, 32'd0);
        check("midreset_rx_active", {31'd0, rx_active}, 32'd0);
        check("midreset_done", {31'd0, done}, 32'd0);
        check("midreset_frame_error", {31'd0, frame_error}, 32'd0);
        in_rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(5);
        frame(8'h12, 1'b1, -1);
        idle(10);
        drain("drain_after_reset");

        // one-clock high pulse in the middle of data bit 2
        frame(8'h00, 1'b1, 2);
        idle(10);
        drain("drain_glitch_bit2");

        // randomized frames
        for (int i = 0; i < 20; i++) begin
            b  = 8'($urandom_range(0, 255));
            sv = ($urandom_range(0, 9) != 0);
            frame(b, sv, -1);
            if (!sv) idle(20);
            else     idle($urandom_range(0, 3));
        end
        idle(10);
        drain("drain_random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Receive half of the board's 8N1 serial link. The block samples the asynchronous `in_rx` line and recovers each frame: start bit, 8 data bits LSB first, and a stop bit. It presents each completed byte with a one-cycle `done` strobe to the command controller, and it pairs with the existing transmitter at the same baud setting. All logic runs on the native 50 MHz board clock.

## Interface
- `CLKS_PER_BIT`, default 5208: clocks per bit, 50 MHz / 9600 baud. Legal range is 8..8191, so it fits in 13 bits.
- `clk`  in  1: native board clock. One clock domain only.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_rx`  in  1: serial line, asynchronous to `clk`. The line idles high.
- `data_received`  out  8: last good byte. Holds its value until the next good frame.
- `rx_active`  out  1: high while a frame is in progress (any state other than IDLE).
- `done`  out  1: one-cycle strobe. Marks a good frame; `data_received` is already valid in that cycle.
- `frame_error`  out  1: one-cycle strobe. Marks a stop bit sampled low.

## Operation
- **Synchronizer:** `in_rx` passes through 2 flops before use. Both flops reset to 1. The synchronized signal is `rx_s`. Define HALF = (CLKS_PER_BIT-1)/2, using integer division.
- **Counters:** `counter` is 13 bits. `bit_index` is 3 bits. `shift` is an 8-bit register.
- **IDLE:**
  - `counter` = 0 and `bit_index` = 0.
  - If `rx_s` == 0, go to START.
- **START:**
  - `counter` increments each clock.
  - At `counter` == HALF, `rx_s` is sampled.
    - If it is 0: `counter` clears and the FSM goes to DATA.
    - If it is 1: the start bit was a glitch. Go to IDLE with no strobe.
- **DATA:**
  - `counter` increments up to CLKS_PER_BIT-1.
  - At CLKS_PER_BIT-1: `shift[bit_index]` ← `rx_s`, and `counter` clears.
  - If `bit_index` == 7, go to STOP. Otherwise `bit_index` increments.
- **STOP:**
  - At `counter` == CLKS_PER_BIT-1, `rx_s` is sampled.
  - If it is 1: `data_received` ← `shift` and `done` = 1.
  - If it is 0: `frame_error` = 1 and `data_received` is unchanged.
  - Either way the FSM returns to IDLE.
  - The sample lands mid stop bit, so a back-to-back next frame is caught from its falling edge.
- **FRAME_ERROR recovery:** after an error the FSM enters IDLE with `rx_s` possibly still low. That is treated as a new start attempt and resolved by the START glitch check. No extra state is used.
- `done` and `frame_error` are never high in the same cycle.
- **Reset values:** `data_received` = 0, `rx_active` = 0, `done` = 0, `frame_error` = 0. The state is IDLE and all counters are 0.
- **Reset mid-frame:** takes effect immediately. The partial byte is discarded with no strobe.

## Timing
- Synchronizer latency is 2 clocks.
- **Sample points** (falling edge of `in_rx` at clock 0):
  - Start bit sampled ≈ HALF+3.
  - Data bit k sampled ≈ HALF+3+(k+1)·CLKS_PER_BIT.
  - Stop bit sampled ≈ HALF+3+9·CLKS_PER_BIT.
- `done` or `frame_error` is asserted in the cycle after the stop-sample edge.
- `rx_active` rises 1 clock after `rx_s` falls. It falls in the same cycle the strobe is asserted.
- Outputs are registered. There are no combinational paths from `in_rx`.
- **Tolerance:** the receiver accepts baud mismatch within ±4% over a 10-bit frame.

## Configuration
- Macro `UART_RX_MAJORITY_EN`.
- **Defined:** each sample point (start check, every data bit, stop bit) takes the 2-of-3 majority of `rx_s`. The three values come from target-2, target-1 and the target count, with the target being HALF or CLKS_PER_BIT-1. One high glitch in those three clocks is rejected.
- **Undefined:** a single sample is taken at the target count.
- Sample positions and strobe timing are identical in both builds.

## Structure
- **Package `uart_pkg`** holds:
  - The state localparams: IDLE=2'b00, START=2'b01, DATA=2'b10, STOP=2'b11. The transmitter shares this encoding.
  - `CLKS_PER_BIT_DEFAULT` = 5208.
  - The counter width of 13.
- **Sub-module `uart_rx_sync`:** the 2-flop synchronizer with reset-to-1, plus the 3-deep sample history used by the majority vote. It outputs `rx_s` and `rx_vote`.

## Test plan
All scenarios use CLKS_PER_BIT = 16.
- **Single byte:** send 0xA5 8N1 at the exact baud → one `done` pulse, `data_received` = 0xA5, `frame_error` never high.
- **Back-to-back frames:** send 0x00 then 0xFF with no idle gap → two `done` pulses, 160±2 clocks apart, with values 0x00 then 0xFF.
- **Glitch rejection:** drive `in_rx` low for 4 clocks, then high → FSM returns to IDLE, no strobe, `rx_active` pulses briefly.
- **Framing error:** send 0x3C with the stop bit low → `frame_error` pulse and no `done`. `data_received` keeps its previous value. A following good 0x81 is received correctly.
- **Reset mid-frame:** assert `rst_n` low during bit 4 of 0x55 → all outputs 0 immediately. After release, a new 0x12 frame gives `done` with 0x12.
- **Majority vote (`UART_RX_MAJORITY_EN`):** inject a 1-clock high glitch on data bit 2 (value 0) at the sample point → the byte is still received correctly. Without the macro the same stimulus flips bit 2.
